// File: rtl/trn_tx_pkg.sv
// Shared types and constants for the TRN transmit arbiter.
// Requester 0 is the completion generator, requester 1 the posted-write engine.
package trn_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DSC  = 2'd2
    } state_t;

    localparam int REQ_CPL     = 0;
    localparam int REQ_PWR     = 1;

    localparam int TBUF_POSTED = 1;
    localparam int TBUF_CPL    = 2;

    localparam logic [7:0] TREM_BOTH  = 8'h00;
    localparam logic [7:0] TREM_UPPER = 8'h0F;

    // Requester rem flag (1 = both DWs) to the core's active-low remainder encoding.
    function automatic logic [7:0] rem_to_trem(input logic rem);
        logic [7:0] trem;
        if (rem) begin
            trem = TREM_BOTH;
        end else begin
            trem = TREM_UPPER;
        end
        return trem;
    endfunction

endpackage

// File: rtl/trn_tx_arbiter_rr_arb2.sv
// Two-way picker: round-robin against the last owner, or fixed requester 0 when prio is set.
module rr_arb2
    import trn_tx_pkg::*;
(
    input  logic [1:0] i_eligible,
    input  logic       i_rr_last,
    input  logic       i_prio,
    output logic       o_grant,
    output logic       o_valid
);

    // Grant selection; a tie goes to requester 0 under prio, else to the one not served last.
    always_comb begin
        o_grant = 1'(REQ_CPL);
        o_valid = 1'b0;
        case (i_eligible)
            2'b01: begin
                o_grant = 1'(REQ_CPL);
                o_valid = 1'b1;
            end
            2'b10: begin
                o_grant = 1'(REQ_PWR);
                o_valid = 1'b1;
            end
            2'b11: begin
                o_valid = 1'b1;
                if (i_prio) begin
                    o_grant = 1'(REQ_CPL);
                end else begin
                    o_grant = ~i_rr_last;
                end
            end
            default: begin
                o_grant = 1'(REQ_CPL);
                o_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/trn_tx_arbiter.sv
// Shares the 64-bit TRN transmit local-link between the completion generator and the
// posted-write engine, switching owners only at TLP boundaries.
module trn_tx_arbiter
    import trn_tx_pkg::*;
#(
    parameter int CPL_PRIORITY = 0,
    parameter int MAX_BEATS    = 32,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    input  logic [127:0]     req_data,
    input  logic [1:0]       req_sof,
    input  logic [1:0]       req_eof,
    input  logic [1:0]       req_rem,
    output logic [1:0]       req_ready,
    output logic [63:0]      trn_td,
    output logic [7:0]       trn_trem_n,
    output logic             trn_tsof_n,
    output logic             trn_teof_n,
    output logic             trn_tsrc_rdy_n,
    output logic             trn_tsrc_dsc_n,
    input  logic             trn_tdst_rdy_n,
    input  logic [3:0]       trn_tbuf_av,
    output logic [CNT_W-1:0] tlp_cnt0,
    output logic [CNT_W-1:0] tlp_cnt1,
    output logic             err_pulse
);

    localparam int BC_W = $clog2(MAX_BEATS + 1);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_owner;
    logic              r_rr_last;
    logic [BC_W-1:0]   r_beat_cnt;
    logic              r_dsc_sent;
    logic [CNT_W-1:0]  r_tlp_cnt0;
    logic [CNT_W-1:0]  r_tlp_cnt1;
    logic              r_err_pulse;

    logic [1:0]        w_space_ok;
    logic [1:0]        w_eligible;
    logic              w_grant;
    logic              w_grant_vld;
    logic              w_own_valid;
    logic              w_own_sof;
    logic              w_own_eof;
    logic              w_own_rem;
    logic [63:0]       w_own_data;
    logic              w_dst_rdy;
    logic              w_beat;
    logic              w_tlp_done;
    logic              w_err;
    logic              w_unused_tbuf;

    assign w_space_ok    = {trn_tbuf_av[TBUF_POSTED], trn_tbuf_av[TBUF_CPL]};
    assign w_eligible    = req_valid & req_sof & w_space_ok;
    assign w_unused_tbuf = ^{trn_tbuf_av[3], trn_tbuf_av[0]};
    assign w_dst_rdy     = ~trn_tdst_rdy_n;

    assign w_own_valid = req_valid[r_owner];
    assign w_own_sof   = req_sof[r_owner];
    assign w_own_eof   = req_eof[r_owner];
    assign w_own_rem   = req_rem[r_owner];
    assign w_own_data  = r_owner ? req_data[127:64] : req_data[63:0];

    rr_arb2 u_rr_arb2 (
        .i_eligible (w_eligible),
        .i_rr_last  (r_rr_last),
        .i_prio     (CPL_PRIORITY != 0),
        .o_grant    (w_grant),
        .o_valid    (w_grant_vld)
    );

    // Next state, TRN datapath mux and requester handshakes.
    always_comb begin
        w_next_state   = r_state;
        trn_td         = 64'h0;
        trn_trem_n     = TREM_BOTH;
        trn_tsof_n     = 1'b1;
        trn_teof_n     = 1'b1;
        trn_tsrc_rdy_n = 1'b1;
        trn_tsrc_dsc_n = 1'b1;
        req_ready      = 2'b00;
        w_beat         = 1'b0;
        w_tlp_done     = 1'b0;
        w_err          = 1'b0;
        case (r_state)
            IDLE: begin
                // Beats arriving without a preceding sof are swallowed one per cycle.
                req_ready = req_valid & ~req_sof;
                w_err     = |(req_valid & ~req_sof);
                if (w_grant_vld) begin
                    w_next_state = BUSY;
                end else begin
                    w_next_state = IDLE;
                end
            end
            BUSY: begin
                if (w_own_valid && w_own_sof && (r_beat_cnt != {BC_W{1'b0}})) begin
                    w_next_state = DSC;
                    w_err        = 1'b1;
                end else begin
                    trn_td         = w_own_data;
                    trn_trem_n     = rem_to_trem(w_own_rem);
                    trn_tsof_n     = ~w_own_sof;
                    trn_teof_n     = ~w_own_eof;
                    trn_tsrc_rdy_n = ~w_own_valid;
                    req_ready      = r_owner ? {w_dst_rdy, 1'b0} : {1'b0, w_dst_rdy};
                    w_beat         = w_own_valid & w_dst_rdy;
                    if (w_beat && w_own_eof) begin
                        w_next_state = IDLE;
                        w_tlp_done   = 1'b1;
                    end else if (w_beat && (r_beat_cnt == BC_W'(MAX_BEATS - 1))) begin
                        w_next_state = DSC;
                        w_err        = 1'b1;
                    end else begin
                        w_next_state = BUSY;
                    end
                end
            end
            DSC: begin
                if (!r_dsc_sent) begin
                    trn_td         = w_own_data;
                    trn_trem_n     = rem_to_trem(w_own_rem);
                    trn_teof_n     = 1'b0;
                    trn_tsrc_rdy_n = 1'b0;
                    trn_tsrc_dsc_n = 1'b0;
                    req_ready      = r_owner ? {w_dst_rdy, 1'b0} : {1'b0, w_dst_rdy};
                    if (w_dst_rdy && w_own_valid && w_own_eof) begin
                        w_next_state = IDLE;
                    end else begin
                        w_next_state = DSC;
                    end
                end else begin
                    req_ready = r_owner ? 2'b10 : 2'b01;
                    if (w_own_valid && w_own_eof) begin
                        w_next_state = IDLE;
                    end else begin
                        w_next_state = DSC;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Owner, fairness pointer, beat count and discontinue bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner    <= 1'b0;
            r_rr_last  <= 1'b1;
            r_beat_cnt <= {BC_W{1'b0}};
            r_dsc_sent <= 1'b0;
        end else begin
            if ((r_state == IDLE) && w_grant_vld) begin
                r_owner <= w_grant;
            end
            if (w_tlp_done) begin
                r_rr_last <= r_owner;
            end
            if (r_state != BUSY) begin
                r_beat_cnt <= {BC_W{1'b0}};
            end else if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + BC_W'(1);
            end
            if (r_state != DSC) begin
                r_dsc_sent <= 1'b0;
            end else if (w_dst_rdy) begin
                r_dsc_sent <= 1'b1;
            end
        end
    end

    // Debug TLP counters and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tlp_cnt0  <= {CNT_W{1'b0}};
            r_tlp_cnt1  <= {CNT_W{1'b0}};
            r_err_pulse <= 1'b0;
        end else begin
            if (w_tlp_done && !r_owner) begin
                r_tlp_cnt0 <= r_tlp_cnt0 + CNT_W'(1);
            end
            if (w_tlp_done && r_owner) begin
                r_tlp_cnt1 <= r_tlp_cnt1 + CNT_W'(1);
            end
            r_err_pulse <= w_err;
        end
    end

    assign tlp_cnt0  = r_tlp_cnt0;
    assign tlp_cnt1  = r_tlp_cnt1;
    assign err_pulse = r_err_pulse;

endmodule

// File: tb/tb_trn_tx_arbiter.sv
// Directed bench: instance 0 is round-robin with MAX_BEATS=4, instance 1 is completion-priority.
module tb_trn_tx_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]   valid  [2];
    logic [127:0] data   [2];
    logic [1:0]   sof    [2];
    logic [1:0]   eof    [2];
    logic [1:0]   rem    [2];
    logic [1:0]   ready  [2];
    logic [63:0]  td     [2];
    logic [7:0]   trem   [2];
    logic         tsof_n [2];
    logic         teof_n [2];
    logic         srdy_n [2];
    logic         dsc_n  [2];
    logic         dst_n  [2];
    logic [3:0]   tbuf   [2];
    logic [15:0]  cnt0   [2];
    logic [15:0]  cnt1   [2];
    logic         err    [2];

    // Requester models: current TLP length, beat index, eof presence, repeat mode.
    int   g_en   [2][2];
    int   g_len  [2][2];
    int   g_idx  [2][2];
    int   g_tlp  [2][2];
    bit   g_eof  [2][2];
    bit   g_cont [2][2];
    bit   g_rem  [2][2];
    logic [3:0] tbuf_nx [2];
    logic       dst_nx  [2];

    logic [7:0] gseq [2];
    int         gcnt [2];
    int         errs [2];
    int         b_r1_ready;
    int         n_chk  = 0;
    int         n_pass = 0;

    trn_tx_arbiter #(.CPL_PRIORITY(0), .MAX_BEATS(4), .CNT_W(16)) u_dut_rr (
        .clk(clk), .rst(rst),
        .req_valid(valid[0]), .req_data(data[0]), .req_sof(sof[0]), .req_eof(eof[0]),
        .req_rem(rem[0]), .req_ready(ready[0]),
        .trn_td(td[0]), .trn_trem_n(trem[0]), .trn_tsof_n(tsof_n[0]), .trn_teof_n(teof_n[0]),
        .trn_tsrc_rdy_n(srdy_n[0]), .trn_tsrc_dsc_n(dsc_n[0]), .trn_tdst_rdy_n(dst_n[0]),
        .trn_tbuf_av(tbuf[0]), .tlp_cnt0(cnt0[0]), .tlp_cnt1(cnt1[0]), .err_pulse(err[0])
    );

    trn_tx_arbiter #(.CPL_PRIORITY(1), .MAX_BEATS(32), .CNT_W(16)) u_dut_pr (
        .clk(clk), .rst(rst),
        .req_valid(valid[1]), .req_data(data[1]), .req_sof(sof[1]), .req_eof(eof[1]),
        .req_rem(rem[1]), .req_ready(ready[1]),
        .trn_td(td[1]), .trn_trem_n(trem[1]), .trn_tsof_n(tsof_n[1]), .trn_teof_n(teof_n[1]),
        .trn_tsrc_rdy_n(srdy_n[1]), .trn_tsrc_dsc_n(dsc_n[1]), .trn_tdst_rdy_n(dst_n[1]),
        .trn_tbuf_av(tbuf[1]), .tlp_cnt0(cnt0[1]), .tlp_cnt1(cnt1[1]), .err_pulse(err[1])
    );

    function automatic logic [63:0] beat(input int r, input int t, input int i);
        return {8'(r), 24'(t), 32'(i)};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive();
        for (int d = 0; d < 2; d++) begin
            tbuf[d]  = tbuf_nx[d];
            dst_n[d] = dst_nx[d];
            for (int r = 0; r < 2; r++) begin
                valid[d][r] = (g_en[d][r] != 0);
                sof[d][r]   = (g_idx[d][r] == 0);
                eof[d][r]   = g_eof[d][r] && (g_idx[d][r] == g_len[d][r] - 1);
                rem[d][r]   = g_rem[d][r];
                data[d][64*r +: 64] = beat(r, g_tlp[d][r], g_idx[d][r]);
            end
        end
    endtask

    task automatic sample_advance();
        for (int d = 0; d < 2; d++) begin
            if (!srdy_n[d] && !dst_n[d] && !tsof_n[d]) begin
                if (gcnt[d] < 8) gseq[d][gcnt[d]] = td[d][56];
                gcnt[d]++;
            end
            if (err[d]) errs[d]++;
            for (int r = 0; r < 2; r++) begin
                if (valid[d][r] && ready[d][r]) begin
                    if (g_idx[d][r] == g_len[d][r] - 1) begin
                        g_idx[d][r] = 0;
                        g_tlp[d][r]++;
                        if (!g_cont[d][r]) g_en[d][r] = 0;
                    end else begin
                        g_idx[d][r]++;
                    end
                end
            end
        end
        if (ready[1][1]) b_r1_ready++;
    endtask

    task automatic cycle();
        @(negedge clk);
        drive();
        #1;
        sample_advance();
    endtask

    task automatic clear_models();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 2; r++) begin
                g_en[d][r] = 0; g_len[d][r] = 1; g_idx[d][r] = 0; g_tlp[d][r] = 0;
                g_eof[d][r] = 1'b1; g_cont[d][r] = 1'b0; g_rem[d][r] = 1'b0;
            end
            tbuf_nx[d] = 4'h0; dst_nx[d] = 1'b0;
            gseq[d] = 8'h00; gcnt[d] = 0; errs[d] = 0;
        end
        b_r1_ready = 0;
    endtask

    task automatic reset_all();
        @(negedge clk);
        rst = 1'b1;
        clear_models();
        drive();
        @(negedge clk);
        rst = 1'b0;
        drive();
    endtask

    logic flag;

    initial begin
        rst = 1'b1;
        clear_models();
        drive();
        repeat (2) @(negedge clk);
        #1;
        check("rst_flags", {60'h0, srdy_n[0], tsof_n[0], teof_n[0], dsc_n[0]}, 64'hF);
        check("rst_td", td[0], 64'h0);
        check("rst_trem", {56'h0, trem[0]}, 64'h00);
        check("rst_ready", {62'h0, ready[0]}, 64'h0);
        check("rst_cnt", {32'h0, cnt0[0], cnt1[0]}, 64'h0);
        check("rst_err", {63'h0, err[0]}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Single 3-beat completion from requester 0.
        g_en[0][0] = 1; g_len[0][0] = 3; g_eof[0][0] = 1'b1; g_rem[0][0] = 1'b0;
        tbuf_nx[0] = 4'b0100;
        cycle();
        check("t1_grant_gap", {63'h0, srdy_n[0]}, 64'h1);
        cycle();
        check("t1_b1_flags", {61'h0, srdy_n[0], tsof_n[0], teof_n[0]}, 64'h1);
        check("t1_b1_td", td[0], beat(0, 0, 0));
        cycle();
        check("t1_b2_flags", {61'h0, srdy_n[0], tsof_n[0], teof_n[0]}, 64'h3);
        check("t1_b2_td", td[0], beat(0, 0, 1));
        cycle();
        check("t1_b3_flags", {61'h0, srdy_n[0], tsof_n[0], teof_n[0]}, 64'h2);
        check("t1_b3_trem", {56'h0, trem[0]}, 64'h0F);
        check("t1_b3_td", td[0], beat(0, 0, 2));
        cycle();
        check("t1_cnt", {32'h0, cnt0[0], cnt1[0]}, {32'h0, 16'd1, 16'd0});
        check("t1_idle", {63'h0, srdy_n[0]}, 64'h1);

        // Beat without sof while idle is dropped with an error pulse.
        g_en[0][1] = 1; g_len[0][1] = 2; g_idx[0][1] = 1;
        cycle();
        check("drop_ready", {62'h0, ready[0]}, 64'h2);
        check("drop_srdy", {63'h0, srdy_n[0]}, 64'h1);
        cycle();
        check("drop_err", {63'h0, err[0]}, 64'h1);

        // Both requesters stream 2-beat TLPs: round-robin vs completion priority.
        reset_all();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 2; r++) begin
                g_en[d][r] = 1; g_len[d][r] = 2; g_cont[d][r] = 1'b1; g_rem[d][r] = 1'b1;
            end
            tbuf_nx[d] = 4'b0110;
        end
        repeat (24) cycle();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 2; r++) g_en[d][r] = 0;
        end
        cycle();
        check("rr_cnt", {32'h0, cnt0[0], cnt1[0]}, {32'h0, 16'd4, 16'd4});
        check("rr_seq", {56'h0, gseq[0]}, 64'hAA);
        check("rr_ntlp", 64'(gcnt[0]), 64'd8);
        check("pr_cnt", {32'h0, cnt0[1], cnt1[1]}, {32'h0, 16'd8, 16'd0});
        check("pr_seq", {56'h0, gseq[1]}, 64'h00);
        check("pr_starve", 64'(b_r1_ready), 64'd0);

        // Posted request held off by missing posted buffer space.
        reset_all();
        g_en[0][1] = 1; g_len[0][1] = 2; g_rem[0][1] = 1'b1;
        flag = 1'b0;
        repeat (10) begin
            cycle();
            if (!srdy_n[0] || (ready[0] != 2'b00)) flag = 1'b1;
        end
        check("t3_gated", {63'h0, flag}, 64'h0);
        tbuf_nx[0] = 4'b0010;
        cycle();
        check("t3_grant_cycle", {63'h0, srdy_n[0]}, 64'h1);
        cycle();
        check("t3_first", {62'h0, srdy_n[0], tsof_n[0]}, 64'h0);
        check("t3_first_td", td[0], beat(1, 0, 0));
        cycle();
        check("t3_last", {55'h0, teof_n[0], trem[0]}, 64'h000);
        cycle();
        check("t3_cnt", {32'h0, cnt0[0], cnt1[0]}, {32'h0, 16'd0, 16'd1});

        // Core backpressure for 5 cycles in the middle of a 4-beat TLP.
        reset_all();
        g_en[0][0] = 1; g_len[0][0] = 4; g_rem[0][0] = 1'b1;
        tbuf_nx[0] = 4'b0100;
        repeat (3) cycle();
        dst_nx[0] = 1'b1;
        flag = 1'b0;
        repeat (5) begin
            cycle();
            if ((td[0] != beat(0, 0, 2)) || !teof_n[0] || (ready[0] != 2'b00) || srdy_n[0])
                flag = 1'b1;
        end
        check("t4_stall", {63'h0, flag}, 64'h0);
        dst_nx[0] = 1'b0;
        cycle();
        check("t4_resume_td", td[0], beat(0, 0, 2));
        cycle();
        check("t4_last_td", td[0], beat(0, 0, 3));
        check("t4_last", {55'h0, teof_n[0], trem[0]}, 64'h000);
        cycle();
        check("t4_cnt", {32'h0, cnt0[0], cnt1[0]}, {32'h0, 16'd1, 16'd0});

        // Overlong 6-beat TLP against MAX_BEATS=4.
        reset_all();
        g_en[0][0] = 1; g_len[0][0] = 6;
        tbuf_nx[0] = 4'b0100;
        repeat (5) cycle();
        check("t5_b4_td", td[0], beat(0, 0, 3));
        check("t5_b4_dsc", {63'h0, dsc_n[0]}, 64'h1);
        cycle();
        check("t5_dsc_flags", {61'h0, srdy_n[0], teof_n[0], dsc_n[0]}, 64'h0);
        check("t5_dsc_td", td[0], beat(0, 0, 4));
        cycle();
        check("t5_flush", {61'h0, srdy_n[0], ready[0]}, 64'h5);
        cycle();
        check("t5_cnt", {32'h0, cnt0[0], cnt1[0]}, 64'h0);
        check("t5_err_once", 64'(errs[0]), 64'd1);
        check("t5_drained", 64'(g_en[0][0]), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
